// File: rtl/capi_mmio_mc_fifo.sv
// Doorbell FIFO between the MMIO capture stage and the command engine.
// Entries are odd-parity checked on entry; bad-parity and overflowing pushes are dropped and flagged.
module capi_mmio_mc_fifo #(
    parameter int ctxtid_width = 10,
    parameter int depth        = 8,
    parameter int depth_width  = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_trg,
    input  logic [0:64]             i_q,
    input  logic [0:ctxtid_width-1] i_ctxt,
    output logic                    o_v,
    input  logic                    i_r,
    output logic [0:64]             o_q,
    output logic [0:ctxtid_width-1] o_ctxt,
    output logic [depth_width:0]    o_cnt,
    output logic                    o_overflow,
    output logic                    o_perror
);

    logic [0:64]             q_mem    [depth];
    logic [0:ctxtid_width-1] ctxt_mem [depth];
    logic [depth_width-1:0]  wr_ptr;
    logic [depth_width-1:0]  rd_ptr;
    logic                    data_ok;
    logic                    ctxt_ok;
    logic                    parity_ok;
    logic                    full;
    logic                    push;
    logic                    pop;

    // Odd parity: the covered bits plus the parity bit always XOR to one.
    assign data_ok   = ^i_q;
    assign ctxt_ok   = ^i_ctxt;
    assign parity_ok = data_ok & ctxt_ok;

    // Full looks only at registered occupancy, so a same-cycle pop never frees a slot.
    assign full = (o_cnt == (depth_width + 1)'(depth));
    assign push = i_trg & parity_ok & ~full;
    assign pop  = o_v & i_r;

    assign o_v    = (o_cnt != '0);
    assign o_q    = q_mem[rd_ptr];
    assign o_ctxt = ctxt_mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_cnt      <= '0;
            o_overflow <= 1'b0;
            o_perror   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + depth_width'(1);
            if (pop)
                rd_ptr <= rd_ptr + depth_width'(1);
            case ({push, pop})
                2'b10:   o_cnt <= o_cnt + (depth_width + 1)'(1);
                2'b01:   o_cnt <= o_cnt - (depth_width + 1)'(1);
                default: o_cnt <= o_cnt;
            endcase
            if (i_trg & ~parity_ok)
                o_perror <= 1'b1;
            if (i_trg & parity_ok & full)
                o_overflow <= 1'b1;
        end
    end

    // Storage needs no reset: contents are only observable while o_v is high.
    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[wr_ptr]    <= i_q;
            ctxt_mem[wr_ptr] <= i_ctxt;
        end
    end

endmodule
